// File: rtl/fetch_stage_ctrl.sv
// IF stage control: next-PC select, PC stall and the IF/ID pipeline register.
// Define BRANCH_DELAY_SLOT_EN to keep the redirect-cycle fetch as a delay slot instead of squashing it.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_INCR      = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] Address,
  output logic        PCStall,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid
);

  typedef enum logic {StRun, StPend} state_t;

  state_t      state_q;
  logic [31:0] pend_target_q;
  logic [31:0] inst_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_aligned;
  logic        squash;

  assign pc_plus4         = PCResult + 32'(PC_INCR);
  assign redirect_aligned = {RedirectTarget[31:2], 2'b00};

`ifdef BRANCH_DELAY_SLOT_EN
  assign squash = 1'b0;
`else
  // A redirect applied now (or a deferred one released now) kills the wrong-path fetch.
  assign squash = Redirect | ((state_q == StPend) & ~Stall);
`endif

  always_comb begin
    Address = pc_plus4;
    if (Redirect) begin
      Address = redirect_aligned;
    end else if (state_q == StPend) begin
      Address = pend_target_q;
    end
  end

  assign PCStall = Stall;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      inst_q        <= 32'h0;
      pc_plus4_q    <= RESET_VECTOR;
      valid_q       <= 1'b0;
      state_q       <= StRun;
      pend_target_q <= RESET_VECTOR;
    end else begin
      if (squash) begin
        inst_q  <= 32'h0;
        valid_q <= 1'b0;
      end else if (!Stall) begin
        inst_q     <= Instruction;
        pc_plus4_q <= pc_plus4;
        valid_q    <= 1'b1;
      end

      case (state_q)
        StRun: begin
          if (Redirect && Stall) begin
            state_q       <= StPend;
            pend_target_q <= redirect_aligned;
          end
        end
        StPend: begin
          // Newest redirect wins while the PC stays frozen.
          if (Redirect && Stall) begin
            pend_target_q <= redirect_aligned;
          end else if (!Stall) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign IF_ID_Instruction = inst_q;
  assign IF_ID_PCPlus4     = pc_plus4_q;
  assign IF_ID_Valid       = valid_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Self-checking bench for fetch_stage_ctrl: directed test-plan steps then random traffic
// compared against a behavioural model of the fetch/redirect rules.
module tb_fetch_stage_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PCResult;
  logic [31:0] Instruction;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] Address;
  logic        PCStall;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;

  int errors = 0;
  int checks = 0;

  // Reference state: a pending redirect is just "is there one" plus "where to".
  logic [31:0] m_inst;
  logic [31:0] m_pc4;
  logic        m_valid;
  bit          m_pending;
  logic [31:0] m_target;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DelaySlot = 1'b1;
`else
  localparam bit DelaySlot = 1'b0;
`endif

  fetch_stage_ctrl dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .PCResult          (PCResult),
    .Instruction       (Instruction),
    .Stall             (Stall),
    .Redirect          (Redirect),
    .RedirectTarget    (RedirectTarget),
    .Address           (Address),
    .PCStall           (PCStall),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Valid       (IF_ID_Valid)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_address();
    if (Redirect) return RedirectTarget & 32'hFFFF_FFFC;
    if (m_pending) return m_target;
    return PCResult + 32'd4;
  endfunction

  task automatic drive(input bit rst, input logic [31:0] pc, input logic [31:0] ins,
                       input bit st, input bit rd, input logic [31:0] tgt);
    Reset          = rst;
    PCResult       = pc;
    Instruction    = ins;
    Stall          = st;
    Redirect       = rd;
    RedirectTarget = tgt;
    #1;
  endtask

  task automatic check_comb();
    if (!Reset) chk("address", Address, model_address());
    chk("pcstall", 32'(PCStall), 32'(Stall));
  endtask

  // Advance one edge, step the model with the inputs seen at that edge, compare IF/ID.
  task automatic tick();
    bit kill;
    @(posedge Clk);
    #1;
    if (Reset) begin
      m_inst = 0; m_pc4 = 0; m_valid = 0; m_pending = 0; m_target = 0;
    end else begin
      kill = !DelaySlot && (Redirect || (m_pending && !Stall));
      if (kill) begin
        m_inst = 0; m_valid = 0;
      end else if (!Stall) begin
        m_inst = Instruction; m_pc4 = PCResult + 32'd4; m_valid = 1;
      end
      if (Redirect && Stall) begin
        m_pending = 1;
        m_target  = RedirectTarget & 32'hFFFF_FFFC;
      end else if (!Stall) begin
        m_pending = 0;
      end
    end
    chk("ifid_inst", IF_ID_Instruction, m_inst);
    chk("ifid_pc4", IF_ID_PCPlus4, m_pc4);
    chk("ifid_valid", 32'(IF_ID_Valid), 32'(m_valid));
  endtask

  initial begin
    m_inst = 0; m_pc4 = 0; m_valid = 0; m_pending = 0; m_target = 0;

    // Reset
    drive(1, 32'h0, 32'h0, 0, 0, 32'h0);
    tick();
    chk("rst_valid", 32'(IF_ID_Valid), 32'h0);
    chk("rst_pc4", IF_ID_PCPlus4, 32'h0);

    // Plain sequential fetch
    drive(0, 32'h0, 32'h2008_0005, 0, 0, 32'h0);
    chk("seq_addr", Address, 32'h4);
    check_comb();
    tick();
    chk("seq_inst", IF_ID_Instruction, 32'h2008_0005);
    chk("seq_pc4", IF_ID_PCPlus4, 32'h4);

    // Stall hold for 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h10, 32'hDEAD_0000 + 32'(i), 1, 0, 32'h0);
      chk("stall_addr", Address, 32'h14);
      check_comb();
      tick();
      chk("stall_hold_inst", IF_ID_Instruction, 32'h2008_0005);
    end

    // Unstalled redirect with misaligned target
    drive(0, 32'h20, 32'h1111_2222, 0, 1, 32'h0000_0043);
    chk("redir_addr", Address, 32'h40);
    check_comb();
    tick();
    chk("redir_valid", 32'(IF_ID_Valid), DelaySlot ? 32'h1 : 32'h0);
    chk("redir_pc4", IF_ID_PCPlus4, DelaySlot ? 32'h24 : 32'h4);

    // Deferred redirect, newest wins, then release
    drive(0, 32'h40, 32'h3333_0000, 1, 1, 32'h80);
    check_comb();
    tick();
    drive(0, 32'h40, 32'h3333_0001, 1, 1, 32'hC0);
    chk("pend_addr_redir", Address, 32'hC0);
    check_comb();
    tick();
    drive(0, 32'h40, 32'h3333_0002, 0, 0, 32'h0);
    chk("release_addr", Address, 32'hC0);
    check_comb();
    tick();
    chk("release_valid", 32'(IF_ID_Valid), DelaySlot ? 32'h1 : 32'h0);
    drive(0, 32'hC0, 32'h4444_0000, 0, 0, 32'h0);
    chk("after_release_addr", Address, 32'hC4);
    tick();

    // PC wrap-around
    drive(0, 32'hFFFF_FFFC, 32'h5555_0000, 0, 0, 32'h0);
    chk("wrap_addr", Address, 32'h0);
    tick();
    chk("wrap_pc4", IF_ID_PCPlus4, 32'h0);

    // Reset discards a pending redirect
    drive(0, 32'h100, 32'h6666_0000, 1, 1, 32'h80);
    tick();
    drive(1, 32'h100, 32'h6666_0001, 1, 0, 32'h0);
    tick();
    chk("rst_mid_valid", 32'(IF_ID_Valid), 32'h0);
    drive(0, 32'h100, 32'h6666_0002, 0, 0, 32'h0);
    chk("rst_mid_addr", Address, 32'h104);
    check_comb();
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), $urandom, $urandom, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), $urandom);
      check_comb();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
